// File: rtl/axi_4_pkg.sv
// Shared AXI4 types for the vector load/store path: slave controller states
// and the response codes it can return.
package axi_4_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    SLAVE_IDLE  = 3'd0,
    READ_FETCH  = 3'd1,
    READ_DATA   = 3'd2,
    WRITE_DATA  = 3'd3,
    WRITE_RESP  = 3'd4
  } axi_4_slave_states_e;

endpackage

// File: rtl/axi_4_slave_controller.sv
// Memory-side AXI4 handshake controller: sequences read/write bursts against a
// one-cycle-latency single-port memory. Optional AXI4_SLAVE_LEN_CHECK_EN flags
// write bursts whose m_wlast disagrees with awlen and drops excess beats.
module axi_4_slave_controller
  import axi_4_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m_arvalid,
  input  logic [LEN_W-1:0] arlen,
  output logic             s_arready,
  output logic             s_rvalid,
  input  logic             m_rready,
  output logic             s_rlast,
  output logic [1:0]       s_rresp,
  input  logic             m_awvalid,
  input  logic [LEN_W-1:0] awlen,
  output logic             s_awready,
  input  logic             m_wvalid,
  input  logic             m_wlast,
  output logic             s_wready,
  output logic             s_bvalid,
  input  logic             m_bready,
  output logic [1:0]       s_bresp,
  output logic             rd_addr_ld,
  output logic             wr_addr_ld,
  output logic             mem_re,
  output logic             mem_we,
  output logic [LEN_W-1:0] mem_beat
);

  axi_4_slave_states_e state_q, state_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       bresp_q, bresp_d;

  // One write beat accepted this cycle, and its index
  logic             wr_take;
  logic [LEN_W-1:0] wr_idx;
`ifdef AXI4_SLAVE_LEN_CHECK_EN
  logic [LEN_W-1:0] wr_len;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SLAVE_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      bresp_q <= AXI_RESP_OKAY;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      bresp_q <= bresp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    len_d      = len_q;
    bresp_d    = bresp_q;
    s_arready  = 1'b0;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rresp    = AXI_RESP_OKAY;
    s_bvalid   = 1'b0;
    s_bresp    = AXI_RESP_OKAY;
    rd_addr_ld = 1'b0;
    wr_addr_ld = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_beat   = '0;
    wr_take    = 1'b0;
    wr_idx     = '0;
`ifdef AXI4_SLAVE_LEN_CHECK_EN
    wr_len     = len_q;
`endif

    // Every output is held low while reset is asserted
    if (reset) begin
      unique case (state_q)
        SLAVE_IDLE: begin
          s_arready = 1'b1;
          s_awready = 1'b1;
          s_wready  = m_awvalid & ~m_arvalid;
          if (m_arvalid) begin
            rd_addr_ld = 1'b1;
            len_d      = arlen;
            beat_d     = '0;
            state_d    = READ_FETCH;
          end else if (m_awvalid) begin
            wr_addr_ld = 1'b1;
            len_d      = awlen;
            wr_take    = m_wvalid;
            wr_idx     = '0;
`ifdef AXI4_SLAVE_LEN_CHECK_EN
            wr_len     = awlen;
`endif
            beat_d     = m_wvalid ? LEN_W'(1) : '0;
            state_d    = (m_wvalid & m_wlast) ? WRITE_RESP : WRITE_DATA;
          end
        end

        READ_FETCH: begin
          mem_re   = 1'b1;
          mem_beat = beat_q;
          state_d  = READ_DATA;
        end

        READ_DATA: begin
          // Memory output holds until the master takes the beat
          s_rvalid = 1'b1;
          s_rlast  = (beat_q == len_q);
          if (m_rready) begin
            if (beat_q == len_q) begin
              state_d = SLAVE_IDLE;
            end else begin
              beat_d  = beat_q + LEN_W'(1);
              state_d = READ_FETCH;
            end
          end
        end

        WRITE_DATA: begin
          s_wready = 1'b1;
          wr_take  = m_wvalid;
          wr_idx   = beat_q;
          if (m_wvalid) begin
            beat_d = beat_q + LEN_W'(1);
            if (m_wlast) state_d = WRITE_RESP;
          end
        end

        WRITE_RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = bresp_q;
          if (m_bready) state_d = SLAVE_IDLE;
        end

        default: state_d = SLAVE_IDLE;
      endcase

      if (wr_take) begin
        mem_beat = wr_idx;
`ifdef AXI4_SLAVE_LEN_CHECK_EN
        // Beats past the announced length are acknowledged but not stored
        mem_we = (wr_idx <= wr_len);
        if (m_wlast)
          bresp_d = (wr_idx != wr_len) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
`else
        mem_we = 1'b1;
`endif
      end
    end
  end

endmodule
